mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multiply/divide unit in the E stage, consuming the MULT/MULTU/DIV/DIVU
//  decode bits of Ex_control_bus plus MTHI/MTLO. Owns the architectural HI/LO registers
//  that MFHI/MFLO read. Holds the pipeline with md_stall until a result is ready.
//  Commits HI/LO only once the E-stage instruction is allowed to advance.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH; HI/LO are WIDTH bits each
// PORTS
//  clk             in   1      clock, all state updates on rising edge
//  rst             in   1      synchronous, active-high reset
//  op_mult         in   1      signed multiply in E (Ex_control_bus bit 10)
//  op_multu        in   1      unsigned multiply in E (bit 11)
//  op_div          in   1      signed divide in E (bit 12)
//  op_divu         in   1      unsigned divide in E (bit 13)
//  op_mthi         in   1      MTHI in E: HI <= src_a
//  op_mtlo         in   1      MTLO in E: LO <= src_a
//  src_a           in   WIDTH  forwarded rs value (multiplicand / dividend)
//  src_b           in   WIDTH  forwarded rt value (multiplier / divisor)
//  pipe_stall_ext  in   1      E stage held by another source this cycle
//  flush           in   1      cancel E-stage instruction (exception/ERET)
//  md_stall        out  1      hold E and earlier stages
//  hi              out  WIDTH  HI register
//  lo              out  WIDTH  LO register
// BEHAVIOUR
//  - Reset: state=IDLE, hi=0, lo=0, counter=0, md_stall=0; rst beats every other input.
//  - start = op_div|op_divu|op_mult|op_multu. If several are set, priority is
//    div > divu > mult > multu.
//  - FSM states: IDLE, MUL, DIV, DONE.
//  - IDLE: if start & ~flush, latch |src_a|, |src_b| (abs only for signed ops), the
//    result signs and the op kind; counter=0; go to MUL or DIV.
//  - MUL: unsigned shift-add, one multiplier bit per cycle.
//  - DIV: restoring divide, one quotient bit per cycle.
//  - MUL/DIV run WIDTH cycles; counter counts 0..WIDTH-1; at WIDTH-1 go to DONE.
//  - DONE: hold sign-corrected result in internal regs.
//    - If ~pipe_stall_ext & ~flush: write {hi,lo} at the clock edge, go to IDLE.
//    - If pipe_stall_ext: stay in DONE, no restart, no write.
//  - md_stall = (IDLE & start & ~flush) | MUL | DIV. md_stall is 0 in DONE.
//  - Latency: md_stall is high exactly WIDTH+1 cycles (33 for the default width).
//    hi/lo show the new value in the cycle after DONE.
//  - flush in any state: next state IDLE, HI/LO untouched, md_stall is 0 from the next cycle.
//  - Signed multiply: negate the 64-bit product when operand signs differ.
//  - Signed divide: quotient negative iff signs differ; remainder takes the dividend sign.
//  - Results: LO = quotient, HI = remainder; for multiply, {HI,LO} = product.
//  - Divide by zero is not trapped. Result: quotient all ones; remainder = src_a.
//    This applies to DIV and DIVU.
//  - DIV 0x80000000 / -1: LO = 0x80000000, HI = 0 (wraps, no trap).
//  - MTHI/MTLO write at the edge when IDLE & ~pipe_stall_ext & ~flush.
//    hi/lo update on the next cycle.
//  - MTHI/MTLO never coincide with start, because the decoder makes them exclusive.
// TESTING
//  1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> md_stall high 33 cycles; then HI=0xFFFFFFFE,
//     LO=0x00000001.
//  2. MULT a=-3 (0xFFFFFFFD) b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//  3. DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     DIVU a=7 b=0 -> LO=0xFFFFFFFF, HI=0x00000007.
//  4. DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0;
//     DIVU same operands -> LO=0, HI=0x80000000.
//  5. flush at iteration 10 of a DIV -> state IDLE next cycle, md_stall=0, HI/LO keep old
//     values; rst at iteration 5 -> hi=lo=0, state IDLE.
//  6. DONE with pipe_stall_ext high 3 cycles, op_div still asserted -> no restart, single
//     HI/LO write after release; then MTHI src_a=0x1234 -> hi=0x1234 next cycle.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative E-stage multiply/divide unit owning the HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_mult,
    input  logic             op_multu,
    input  logic             op_div,
    input  logic             op_divu,
    input  logic             op_mthi,
    input  logic             op_mtlo,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             pipe_stall_ext,
    input  logic             flush,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               w_start, w_is_div, w_signed, w_a_neg, w_b_neg, w_last;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_mul_sum, w_div_trial;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_raw, w_fixed;
    logic [WIDTH-1:0]   w_raw_hi, w_raw_lo;

    always_comb begin
        w_start  = op_div | op_divu | op_mult | op_multu;
        w_is_div = op_div | op_divu;
        w_signed = op_div | (~op_divu & op_mult);
        w_a_neg  = w_signed & src_a[WIDTH-1];
        w_b_neg  = w_signed & src_b[WIDTH-1];
        w_abs_a  = w_a_neg ? -src_a : src_a;
        w_abs_b  = w_b_neg ? -src_b : src_b;
        w_last   = (cnt_q == CW'(WIDTH-1));

        // Shift-add: acc = {partial product, remaining multiplier bits}
        w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: acc = {partial remainder, dividend/quotient bits}
        w_div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        w_div_next  = w_div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                         : {w_div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        w_raw    = is_div_q ? w_div_next : w_mul_next;
        w_raw_hi = w_raw[2*WIDTH-1:WIDTH];
        w_raw_lo = w_raw[WIDTH-1:0];
        if (is_div_q) begin
            w_fixed = {neg_hi_q ? -w_raw_hi : w_raw_hi, neg_lo_q ? -w_raw_lo : w_raw_lo};
        end else begin
            w_fixed = neg_lo_q ? -w_raw : w_raw;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        md_stall = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_start & ~flush) begin
                    md_stall = 1'b1;
                    state_d  = w_is_div ? S_DIV : S_MUL;
                    cnt_d    = '0;
                    opnd_d   = w_is_div ? w_abs_b : w_abs_a;
                    acc_d    = {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                    // Divide by zero keeps an all-ones quotient unsigned
                    neg_lo_d = (w_a_neg ^ w_b_neg) & (~w_is_div | (src_b != '0));
                    neg_hi_d = w_a_neg;
                    is_div_d = w_is_div;
                end else if (~pipe_stall_ext & ~flush) begin
                    if (op_mthi) hi_d = src_a;
                    if (op_mtlo) lo_d = src_a;
                end
            end
            S_MUL, S_DIV: begin
                md_stall = 1'b1;
                acc_d    = w_last ? w_fixed : w_raw;
                cnt_d    = cnt_q + CW'(1);
                if (w_last) state_d = S_DONE;
            end
            S_DONE: begin
                if (~pipe_stall_ext & ~flush) begin
                    hi_d    = acc_q[2*WIDTH-1:WIDTH];
                    lo_d    = acc_q[WIDTH-1:0];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Self-checking bench for mul_div_unit (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    logic [31:0] src_a, src_b;
    logic        pipe_stall_ext, flush;
    logic        md_stall;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_hi_r = '0;
    logic [31:0] exp_lo_r = '0;

    // ops encoding: [0]=mult [1]=multu [2]=div [3]=divu
    typedef struct {
        logic [3:0]  ops;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t tbl[15];

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
        .op_mthi(op_mthi), .op_mtlo(op_mtlo),
        .src_a(src_a), .src_b(src_b),
        .pipe_stall_ext(pipe_stall_ext), .flush(flush),
        .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %0s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] ops, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sq, sr;
        if (ops[2]) begin
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return {sr, sq};
        end else if (ops[3]) begin
            return {a % b, a / b};
        end else if (ops[0]) begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return sp;
        end else begin
            return {32'b0, a} * {32'b0, b};
        end
    endfunction

    task automatic set_ops(input logic [3:0] ops);
        {op_divu, op_div, op_multu, op_mult} = ops;
    endtask

    task automatic pop_check(input string name);
        logic [63:0] e;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({name, "_hi"}, {32'b0, hi}, {32'b0, e[63:32]});
            check({name, "_lo"}, {32'b0, lo}, {32'b0, e[31:0]});
            exp_hi_r = e[63:32];
            exp_lo_r = e[31:0];
        end
    endtask

    // Issue one op, count md_stall cycles, let DONE commit, then compare.
    task automatic run_op(input string name, input logic [3:0] ops, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int n;
        @(negedge clk);
        set_ops(ops);
        src_a = a;
        src_b = b;
        sb_q.push_back(exp);
        #1;
        n = 0;
        while (md_stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({name, "_stall_cycles"}, 64'(n), 64'd33);
        set_ops(4'b0000);
        @(negedge clk);
        #1;
        pop_check(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        tbl[0]  = '{4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[1]  = '{4'b0001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[2]  = '{4'b0100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{4'b1000, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        tbl[4]  = '{4'b0100, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[5]  = '{4'b1000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        tbl[6]  = '{4'b0100, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tbl[7]  = '{4'b0100, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
        tbl[8]  = '{4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        tbl[9]  = '{4'b0010, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        tbl[10] = '{4'b0101, 32'd20,       32'd3,        32'd2,        32'd6};
        tbl[11] = '{4'b1011, 32'hFFFFFFF0, 32'd16,       32'h00000000, 32'h0FFFFFFF};
        tbl[12] = '{4'b0001, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
        tbl[13] = '{4'b0011, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[14] = '{4'b1000, 32'd100,      32'd7,        32'd2,        32'd14};

        rst = 1'b1;
        set_ops(4'b0000);
        op_mthi = 1'b0;
        op_mtlo = 1'b0;
        src_a = '0;
        src_b = '0;
        pipe_stall_ext = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_hi", {32'b0, hi}, 64'd0);
        check("reset_lo", {32'b0, lo}, 64'd0);
        check("reset_stall", {63'b0, md_stall}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].ops, tbl[i].a, tbl[i].b,
                   {tbl[i].hi, tbl[i].lo});
        end

        for (int i = 0; i < 8; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            if (rb == 0) rb = 1;
            if (ra == 32'h80000000) ra = 32'h1;
            rop = 4'b0001 << (i % 4);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb));
        end

        // flush partway through a divide
        @(negedge clk);
        set_ops(4'b0100);
        src_a = 32'd1000;
        src_b = 32'd3;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_cycle_stall", {63'b0, md_stall}, 64'd1);
        @(negedge clk);
        flush = 1'b0;
        set_ops(4'b0000);
        #1;
        check("flush_stall", {63'b0, md_stall}, 64'd0);
        check("flush_hi", {32'b0, hi}, {32'b0, exp_hi_r});
        check("flush_lo", {32'b0, lo}, {32'b0, exp_lo_r});
        repeat (40) @(negedge clk);
        #1;
        check("flush_late_stall", {63'b0, md_stall}, 64'd0);
        check("flush_late_lo", {32'b0, lo}, {32'b0, exp_lo_r});

        // reset partway through a multiply
        @(negedge clk);
        set_ops(4'b0001);
        src_a = 32'd3;
        src_b = 32'd5;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_ops(4'b0000);
        #1;
        exp_hi_r = '0;
        exp_lo_r = '0;
        check("rst_mid_hi", {32'b0, hi}, 64'd0);
        check("rst_mid_lo", {32'b0, lo}, 64'd0);
        check("rst_mid_stall", {63'b0, md_stall}, 64'd0);
        @(negedge clk);
        #1;
        check("rst_mid_idle", {63'b0, md_stall}, 64'd0);

        // DONE held by an external stall with the divide still decoded
        @(negedge clk);
        set_ops(4'b0100);
        src_a = 32'd100;
        src_b = 32'd7;
        sb_q.push_back({32'd2, 32'd14});
        #1;
        for (int n = 0; n < 100 && md_stall; n++) begin
            @(negedge clk);
            #1;
        end
        pipe_stall_ext = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("hold%0d_stall", k), {63'b0, md_stall}, 64'd0);
            check($sformatf("hold%0d_hilo", k), {hi, lo}, {exp_hi_r, exp_lo_r});
        end
        pipe_stall_ext = 1'b0;
        @(negedge clk);
        set_ops(4'b0000);
        #1;
        pop_check("hold_release");
        repeat (3) @(negedge clk);
        #1;
        check("hold_single_write_stall", {63'b0, md_stall}, 64'd0);
        check("hold_single_write", {hi, lo}, {exp_hi_r, exp_lo_r});

        // MTHI/MTLO, including a stalled attempt that must not write
        @(negedge clk);
        pipe_stall_ext = 1'b1;
        op_mthi = 1'b1;
        src_a = 32'hDEAD0000;
        @(negedge clk);
        pipe_stall_ext = 1'b0;
        op_mthi = 1'b0;
        #1;
        check("mthi_stalled", {32'b0, hi}, {32'b0, exp_hi_r});
        op_mthi = 1'b1;
        src_a = 32'h00001234;
        @(negedge clk);
        op_mthi = 1'b0;
        #1;
        check("mthi_hi", {32'b0, hi}, 64'h1234);
        check("mthi_lo_kept", {32'b0, lo}, {32'b0, exp_lo_r});
        op_mtlo = 1'b1;
        src_a = 32'h00005678;
        @(negedge clk);
        op_mtlo = 1'b0;
        #1;
        check("mtlo_lo", {32'b0, lo}, 64'h5678);
        check("mtlo_hi_kept", {32'b0, hi}, 64'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
